// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - decode-stage hazard stall, branch flush and halt scheduler
//
// Ports:
//   clk             rising-edge clock
//   i_reset         synchronous active-high reset
//   i_id_*          ID-stage instruction operands and kind (rs, rt, uses_rt, branch, halt)
//   i_branch_taken  branch resolved taken in ID this cycle
//   i_ex_*          EX-stage load / register-write flags and destination
//   i_mem_*         MEM-stage load flag and destination
//   o_pc_write      PC load enable
//   o_if_id_write   IF/ID load enable
//   o_if_id_flush   IF/ID clear for a taken branch
//   o_id_ex_bubble  insert NOP into ID/EX
//   o_halted        core halted, left only through reset
//   o_stall_cycles  saturating count of hazard stall cycles since reset
module hazard_stall_ctrl #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_id_is_branch,
  input  logic              i_branch_taken,
  input  logic              i_id_halt,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_reg_write,
  input  logic [NB_REG-1:0] i_ex_rd,
  input  logic              i_mem_mem_read,
  input  logic [NB_REG-1:0] i_mem_rd,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [1:0]  rem, next_rem;
  logic [1:0]  need;
  logic        ex_match, mem_match;
  logic        stall_cycle;

  // Register 0 is hardwired zero, so writes to it never create a dependency.
  always_comb begin
    ex_match  = (i_ex_rd != '0) &&
                ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    mem_match = (i_mem_rd != '0) &&
                ((i_mem_rd == i_id_rs) || (i_id_uses_rt && (i_mem_rd == i_id_rt)));
  end

  // Branches compare operands in ID, so they cannot use the EX/MEM forwarding
  // paths that ALU ops in EX get; a load feeding a branch needs two bubbles.
  always_comb begin
    need = 2'd0;
    if (i_ex_mem_read && ex_match) begin
      need = i_id_is_branch ? 2'd2 : 2'd1;
    end else if (i_id_is_branch &&
                 ((i_ex_reg_write && ex_match) || (i_mem_mem_read && mem_match))) begin
      need = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= next_state;
      rem   <= next_rem;
    end
  end

  always_comb begin
    next_state     = state;
    next_rem       = rem;
    stall_cycle    = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b1;
    o_halted       = 1'b0;
    if (!i_reset) begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            // A taken branch is not flushed here; it is re-resolved after the stall.
            stall_cycle = 1'b1;
            if (need == 2'd2) begin
              next_state = STALL;
              next_rem   = 2'd1;
            end
          end else if (i_id_halt) begin
            // Let HALT itself move into EX, then freeze the front end.
            o_id_ex_bubble = 1'b0;
            next_state     = HALTED;
          end else begin
            o_pc_write     = 1'b1;
            o_if_id_write  = 1'b1;
            o_id_ex_bubble = 1'b0;
            o_if_id_flush  = i_branch_taken;
          end
        end
        STALL: begin
          stall_cycle = 1'b1;
          next_rem    = rem - 2'd1;
          if (rem <= 2'd1) begin
            next_state = RUN;
          end
        end
        HALTED: begin
          o_halted = 1'b1;
        end
        default: begin
          next_state = RUN;
          next_rem   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
    end else if (stall_cycle && (o_stall_cycles != {NB_CNT{1'b1}})) begin
      o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 4;

  logic              clk;
  logic              i_reset;
  logic [NB_REG-1:0] i_id_rs, i_id_rt, i_ex_rd, i_mem_rd;
  logic              i_id_uses_rt, i_id_is_branch, i_branch_taken, i_id_halt;
  logic              i_ex_mem_read, i_ex_reg_write, i_mem_mem_read;
  logic              o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted;
  logic [NB_CNT-1:0] o_stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  hazard_stall_ctrl #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_uses_rt   (i_id_uses_rt),
    .i_id_is_branch (i_id_is_branch),
    .i_branch_taken (i_branch_taken),
    .i_id_halt      (i_id_halt),
    .i_ex_mem_read  (i_ex_mem_read),
    .i_ex_reg_write (i_ex_reg_write),
    .i_ex_rd        (i_ex_rd),
    .i_mem_mem_read (i_mem_mem_read),
    .i_mem_rd       (i_mem_rd),
    .o_pc_write     (o_pc_write),
    .o_if_id_write  (o_if_id_write),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_bubble (o_id_ex_bubble),
    .o_halted       (o_halted),
    .o_stall_cycles (o_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    i_id_rs = '0; i_id_rt = '0; i_ex_rd = '0; i_mem_rd = '0;
    i_id_uses_rt = 0; i_id_is_branch = 0; i_branch_taken = 0; i_id_halt = 0;
    i_ex_mem_read = 0; i_ex_reg_write = 0; i_mem_mem_read = 0;
  endtask

  // Advance past the next rising edge; inputs are then changed and checked at the negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  // {pc_write, if_id_write, flush, bubble, halted}
  task automatic test_reset();
    quiet();
    i_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted} !== 5'b00010) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got %b want 00010", c,
                 {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted});
      end
      tick();
    end
    i_reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 11000",
               {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted});
    end
    vectors++;
    if (o_stall_cycles !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_counter: got %0d want 0", o_stall_cycles);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    i_ex_mem_read = 1; i_ex_rd = 5'd5; i_id_rs = 5'd5;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_id_ex_bubble} !== 3'b001) begin
      miscompares++;
      $display("FAIL load_use_stall: got %b want 001", {o_pc_write, o_if_id_write, o_id_ex_bubble});
    end
    tick();
    // load has advanced to MEM; non-branch consumer needs no further stall
    quiet();
    i_mem_mem_read = 1; i_mem_rd = 5'd5; i_id_rs = 5'd5;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_id_ex_bubble} !== 3'b110) begin
      miscompares++;
      $display("FAIL load_use_resume: got %b want 110", {o_pc_write, o_if_id_write, o_id_ex_bubble});
    end
    vectors++;
    if (o_stall_cycles !== 4'd1) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d want 1", o_stall_cycles);
    end
    tick();
    quiet();
    i_ex_mem_read = 1; i_ex_rd = 5'd0; i_id_rs = 5'd0;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_id_ex_bubble} !== 2'b10) begin
      miscompares++;
      $display("FAIL load_r0_no_stall: got %b want 10", {o_pc_write, o_id_ex_bubble});
    end
    tick();
    @(negedge clk);
    vectors++;
    if (o_stall_cycles !== 4'd1) begin
      miscompares++;
      $display("FAIL load_r0_count: got %0d want 1", o_stall_cycles);
    end
    tick();
  endtask

  task automatic test_branch_load();
    do_reset();
    i_ex_mem_read = 1; i_ex_rd = 5'd7; i_id_rt = 5'd7; i_id_uses_rt = 1;
    i_id_is_branch = 1; i_branch_taken = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble} !== 4'b0001) begin
      miscompares++;
      $display("FAIL br_load_stall1: got %b want 0001",
               {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble});
    end
    tick();
    // second stall cycle must ignore these inputs entirely
    quiet();
    i_id_halt = 1; i_id_is_branch = 1; i_branch_taken = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted} !== 5'b00010) begin
      miscompares++;
      $display("FAIL br_load_stall2: got %b want 00010",
               {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted});
    end
    vectors++;
    if (o_stall_cycles !== 4'd1) begin
      miscompares++;
      $display("FAIL br_load_count_mid: got %0d want 1", o_stall_cycles);
    end
    tick();
    quiet();
    i_id_is_branch = 1; i_branch_taken = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble} !== 4'b1110) begin
      miscompares++;
      $display("FAIL br_load_flush: got %b want 1110",
               {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble});
    end
    vectors++;
    if (o_stall_cycles !== 4'd2) begin
      miscompares++;
      $display("FAIL br_load_count: got %0d want 2", o_stall_cycles);
    end
    tick();
    quiet();
    @(negedge clk);
    vectors++;
    if (o_if_id_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL br_load_flush_once: got %b want 0", o_if_id_flush);
    end
    tick();
  endtask

  task automatic test_branch_alu();
    do_reset();
    // ALU result in EX feeding a non-branch is forwarded: no stall
    i_ex_reg_write = 1; i_ex_rd = 5'd3; i_id_rs = 5'd3;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_id_ex_bubble} !== 2'b10) begin
      miscompares++;
      $display("FAIL alu_nonbranch: got %b want 10", {o_pc_write, o_id_ex_bubble});
    end
    tick();
    i_id_is_branch = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_id_ex_bubble} !== 3'b001) begin
      miscompares++;
      $display("FAIL br_alu_stall: got %b want 001", {o_pc_write, o_if_id_write, o_id_ex_bubble});
    end
    tick();
    quiet();
    i_id_is_branch = 1; i_mem_mem_read = 1; i_mem_rd = 5'd4; i_id_rt = 5'd4; i_id_uses_rt = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_id_ex_bubble} !== 3'b001) begin
      miscompares++;
      $display("FAIL br_mem_stall: got %b want 001", {o_pc_write, o_if_id_write, o_id_ex_bubble});
    end
    tick();
    // same MEM load, but rt not read: no dependency
    i_id_uses_rt = 0;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_id_ex_bubble} !== 2'b10) begin
      miscompares++;
      $display("FAIL br_mem_no_rt: got %b want 10", {o_pc_write, o_id_ex_bubble});
    end
    vectors++;
    if (o_stall_cycles !== 4'd2) begin
      miscompares++;
      $display("FAIL br_alu_count: got %0d want 2", o_stall_cycles);
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    i_id_halt = 1;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_if_id_write, o_id_ex_bubble, o_halted} !== 4'b0000) begin
      miscompares++;
      $display("FAIL halt_enter: got %b want 0000", {o_pc_write, o_if_id_write, o_id_ex_bubble, o_halted});
    end
    tick();
    quiet();
    i_ex_mem_read = 1; i_ex_rd = 5'd2; i_id_rs = 5'd2; i_branch_taken = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted} !== 5'b00011) begin
        miscompares++;
        $display("FAIL halted_hold cyc%0d: got %b want 00011", c,
                 {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted});
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (o_stall_cycles !== 4'd0) begin
      miscompares++;
      $display("FAIL halted_count: got %0d want 0", o_stall_cycles);
    end
    tick();
    quiet();
    i_reset = 1;
    @(negedge clk);
    vectors++;
    if ({o_halted, o_id_ex_bubble} !== 2'b01) begin
      miscompares++;
      $display("FAIL halt_reset_force: got %b want 01", {o_halted, o_id_ex_bubble});
    end
    tick();
    i_reset = 0;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_halted} !== 2'b10) begin
      miscompares++;
      $display("FAIL halt_reset_run: got %b want 10", {o_pc_write, o_halted});
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    i_ex_mem_read = 1; i_ex_rd = 5'd9; i_id_rs = 5'd9; i_id_is_branch = 1;
    tick();
    quiet();
    i_reset = 1;
    tick();
    i_reset = 0;
    @(negedge clk);
    vectors++;
    if ({o_pc_write, o_id_ex_bubble} !== 2'b10 || o_stall_cycles !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got pc/bub=%b cnt=%0d want 10 cnt=0",
               {o_pc_write, o_id_ex_bubble}, o_stall_cycles);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    i_ex_mem_read = 1; i_ex_rd = 5'd6; i_id_rs = 5'd6;
    for (int c = 0; c < 20; c++) begin
      if (c == 14) begin
        @(negedge clk);
        vectors++;
        if (o_stall_cycles !== 4'd14) begin
          miscompares++;
          $display("FAIL sat_pre: got %0d want 14", o_stall_cycles);
        end
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (o_stall_cycles !== 4'hF) begin
      miscompares++;
      $display("FAIL sat_hold: got %0d want 15", o_stall_cycles);
    end
    vectors++;
    if (o_pc_write !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_still_stalling: got %b want 0", o_pc_write);
    end
    tick();
  endtask

  initial begin
    quiet();
    i_reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_halt();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Decode-stage pipeline scheduler for the MIPS/DLX core.
- Detects RAW hazards between the instruction in ID (whose immediate goes through the sign extender) and the loads/ALU ops in EX and MEM.
- Sequences pc / IF-ID / ID-EX register control for multi-cycle stalls, branch flushes and HALT drain, and keeps a saturating stall-cycle performance counter for the debug unit.

Parameters:
- NB_REG, 5, register address width
- NB_CNT, 16, stall-cycle counter width

Ports:
- clk  input  1  system clock, rising edge
- i_reset  input  1  synchronous active-high reset
- i_id_rs  input  NB_REG  rs of the instruction in ID
- i_id_rt  input  NB_REG  rt of the instruction in ID
- i_id_uses_rt  input  1  ID instruction reads rt (R-type, store, branch)
- i_id_is_branch  input  1  ID holds beq/bne/jr (operands compared in ID)
- i_branch_taken  input  1  branch resolved taken in ID this cycle
- i_id_halt  input  1  ID holds HALT
- i_ex_mem_read  input  1  EX instruction is a load
- i_ex_reg_write  input  1  EX instruction writes a register
- i_ex_rd  input  NB_REG  EX destination register
- i_mem_mem_read  input  1  MEM instruction is a load
- i_mem_rd  input  NB_REG  MEM destination register
- o_pc_write  output  1  PC load enable
- o_if_id_write  output  1  IF/ID load enable
- o_if_id_flush  output  1  IF/ID clear (taken branch)
- o_id_ex_bubble  output  1  insert NOP into ID/EX
- o_halted  output  1  core halted
- o_stall_cycles  output  NB_CNT  hazard stall cycles since reset

Behaviour:
- States: RUN, STALL, HALTED; register rem (2 bits); register o_stall_cycles.
- Reset (i_reset=1 at a clock edge): state=RUN, rem=0, o_stall_cycles=0. While i_reset is high, outputs are forced to pc_write=0, if_id_write=0, flush=0, bubble=1, halted=0. Reset mid-stall or in HALTED returns to RUN.
- match(r) = (r != 0) && (r == i_id_rs || (i_id_uses_rt && r == i_id_rt)). Register 0 never causes a hazard.
- Required stalls N, evaluated only in RUN:
  - i_ex_mem_read && match(i_ex_rd): N=2 if i_id_is_branch, else N=1.
  - else i_id_is_branch && ((i_ex_reg_write && match(i_ex_rd)) || (i_mem_mem_read && match(i_mem_rd))): N=1.
  - else N=0.
- RUN, N>0: stall cycle (pc_write=0, if_id_write=0, bubble=1, flush=0). Next state is STALL with rem=1 if N=2; otherwise stay RUN and re-evaluate next cycle.
- STALL: stall outputs; inputs are not re-evaluated; rem decrements; at rem=1 the next state is RUN.
- RUN, N=0, i_id_halt: pc_write=0, if_id_write=0, bubble=0 (HALT enters EX); next state HALTED.
- RUN, N=0, no halt: pc_write=1, if_id_write=1, bubble=0, flush=i_branch_taken.
- Priority: hazard stall > halt > branch flush. A taken branch seen during a stall cycle is ignored; the branch is re-resolved after the stall.
- HALTED: pc_write=0, if_id_write=0, bubble=1, flush=0, halted=1. Exit only by reset.
- o_stall_cycles increments on every hazard stall cycle (RUN with N>0, or STALL). Not incremented in HALTED or during reset. Saturates at all-ones (no wrap).
- All outputs are combinational from state and inputs; no added latency beyond the same cycle.

Test Plan:
- Reset held 3 cycles, then released with quiet inputs -> bubble=1/pc_write=0 during reset; after release pc_write=1, if_id_write=1, o_stall_cycles=0.
- ex_mem_read=1, ex_rd=5, id_rs=5, non-branch -> exactly one cycle pc_write=0, bubble=1; o_stall_cycles=1; same stimulus with ex_rd=0 -> no stall.
- ex_mem_read=1, ex_rd=7, id_rt=7, uses_rt=1, is_branch=1, branch_taken=1 -> 2 stall cycles with flush=0 (inputs changed in the 2nd cycle are ignored); then flush=1 for one cycle; counter=2.
- is_branch=1, ex_reg_write=1, ex_rd=3, id_rs=3 -> 1 stall; is_branch=1, mem_mem_read=1, mem_rd=4, id_rt=4, uses_rt=1 -> 1 stall.
- id_halt=1 with no hazard -> one cycle bubble=0/pc_write=0, then o_halted=1 indefinitely; assert i_reset -> RUN, halted=0.
- Preload counter near max (force/long run, NB_CNT=4): 20 stall cycles -> o_stall_cycles holds 4'hF.
